// File: rtl/mips_pkg.sv
// Shared MIPS datapath types and helpers used by the HI/LO multiply unit.
package mips_pkg;

  localparam int unsigned MIPS_WORD = 32;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FIX
  } hilo_state_t;

  // Magnitude of a word; treated as two's complement only when signed_flag is set.
  // -2^(MIPS_WORD-1) maps to 2^(MIPS_WORD-1), which is representable unsigned.
  function automatic logic [MIPS_WORD-1:0] abs_word(input logic [MIPS_WORD-1:0] value,
                                                    input logic                 signed_flag);
    logic [MIPS_WORD-1:0] w_mag;
    w_mag = value;
    if (signed_flag && value[MIPS_WORD-1]) begin
      w_mag = -value;
    end
    return w_mag;
  endfunction

endpackage

// File: rtl/hilo_mult_dp.sv
// Shift-add datapath: accumulator, multiplicand and multiplier registers with one adder.
module hilo_mult_dp #(
  parameter int unsigned WIDTH = 32
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_load,
  input  logic               i_step,
  input  logic [WIDTH-1:0]   i_a_mag,
  input  logic [WIDTH-1:0]   i_b_mag,
  output logic [2*WIDTH-1:0] o_acc
);

  logic [2*WIDTH-1:0] r_acc;
  logic [2*WIDTH-1:0] r_mcand;
  logic [WIDTH-1:0]   r_mplier;
  logic [2*WIDTH-1:0] w_sum;

  // Magnitudes are below 2^WIDTH each, so the product never overflows 2*WIDTH bits.
  assign w_sum = r_acc + r_mcand;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_acc    <= '0;
      r_mcand  <= '0;
      r_mplier <= '0;
    end else if (i_load) begin
      r_acc    <= '0;
      r_mcand  <= {{WIDTH{1'b0}}, i_a_mag};
      r_mplier <= i_b_mag;
    end else if (i_step) begin
      if (r_mplier[0]) begin
        r_acc <= w_sum;
      end
      r_mcand  <= r_mcand << 1;
      r_mplier <= r_mplier >> 1;
    end
  end

  assign o_acc = r_acc;

endmodule

// File: rtl/hilo_mult_unit.sv
// Iterative MULT/MULTU unit with architectural HI/LO registers and upstream stall.
module hilo_mult_unit
  import mips_pkg::*;
#(
  parameter int unsigned WIDTH = MIPS_WORD,
  parameter int unsigned CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             signed_op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             hilo_rd,
  input  logic             hi_lo_sel,
  output logic [WIDTH-1:0] hilo_out,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             done,
  output logic             stall
);

  localparam logic [CNT_W-1:0] CntLast = CNT_W'(WIDTH - 1);

  hilo_state_t        r_state;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_neg;
  logic [WIDTH-1:0]   r_hi;
  logic [WIDTH-1:0]   r_lo;
  logic               r_done;

  logic               w_accept;
  logic               w_busy;
  logic [WIDTH-1:0]   w_a_mag;
  logic [WIDTH-1:0]   w_b_mag;
  logic [2*WIDTH-1:0] w_acc;
  logic [2*WIDTH-1:0] w_prod;

  assign w_busy   = (r_state != IDLE);
  assign w_accept = start && (r_state == IDLE);

  // abs_word is MIPS_WORD wide; this unit is instantiated with WIDTH == MIPS_WORD.
  assign w_a_mag = abs_word(a, signed_op);
  assign w_b_mag = abs_word(b, signed_op);

  assign w_prod = r_neg ? -w_acc : w_acc;

  hilo_mult_dp #(
    .WIDTH (WIDTH)
  ) u_dp (
    .i_clk   (clk),
    .i_rst_n (rst),
    .i_load  (w_accept),
    .i_step  (r_state == RUN),
    .i_a_mag (w_a_mag),
    .i_b_mag (w_b_mag),
    .o_acc   (w_acc)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_neg   <= 1'b0;
      r_hi    <= '0;
      r_lo    <= '0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      unique case (r_state)
        IDLE: begin
          if (start) begin
            r_neg   <= signed_op & (a[WIDTH-1] ^ b[WIDTH-1]);
            r_cnt   <= '0;
            r_state <= RUN;
          end
        end
        RUN: begin
          r_cnt <= r_cnt + CNT_W'(1);
          if (r_cnt == CntLast) begin
            r_state <= FIX;
          end
        end
        FIX: begin
          {r_hi, r_lo} <= w_prod;
          r_done       <= 1'b1;
          r_state      <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // A held start in IDLE stalls too, so the issuing instruction never slips past.
  assign stall    = w_busy | w_accept | (hilo_rd & w_busy);
  assign busy     = w_busy;
  assign done     = r_done;
  assign hi       = r_hi;
  assign lo       = r_lo;
  assign hilo_out = hi_lo_sel ? r_hi : r_lo;

endmodule

// File: tb/tb_hilo_mult_unit.sv
// Directed and randomized checks of hilo_mult_unit against an arithmetic product model.
module tb_hilo_mult_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic        signed_op = 1'b0;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic        hilo_rd = 1'b0;
  logic        hi_lo_sel = 1'b0;
  logic [31:0] hilo_out;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        busy;
  logic        done;
  logic        stall;

  int          n_checks = 0;
  int          n_fail = 0;
  logic [31:0] last_hi = '0;
  logic [31:0] last_lo = '0;

  hilo_mult_unit #(
    .WIDTH (32),
    .CNT_W (6)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .signed_op (signed_op),
    .a         (a),
    .b         (b),
    .hilo_rd   (hilo_rd),
    .hi_lo_sel (hi_lo_sel),
    .hilo_out  (hilo_out),
    .hi        (hi),
    .lo        (lo),
    .busy      (busy),
    .done      (done),
    .stall     (stall)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] ref_prod(input logic [31:0] x, input logic [31:0] y,
                                           input logic s);
    longint sx;
    longint sy;
    if (s) begin
      sx = $signed(x);
      sy = $signed(y);
      return sx * sy;
    end
    return {32'd0, x} * {32'd0, y};
  endfunction

  // Issues one multiply and checks latency, busy span, done-cycle flags and the result.
  task automatic run_mult(input logic [31:0] ta, input logic [31:0] tb_v, input logic ts,
                          input string tag);
    int          edges;
    int          busy_cyc;
    logic [63:0] exp;
    exp = ref_prod(ta, tb_v, ts);
    @(negedge clk);
    a = ta;
    b = tb_v;
    signed_op = ts;
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    edges = 0;
    busy_cyc = 0;
    while (done !== 1'b1 && edges < 100) begin
      if (busy === 1'b1) busy_cyc++;
      @(negedge clk);
      edges++;
    end
    chk({tag, "_latency"}, 64'(edges), 64'd33);
    chk({tag, "_busy_cycles"}, 64'(busy_cyc), 64'd33);
    chk({tag, "_busy_in_done"}, 64'(busy), 64'd0);
    chk({tag, "_stall_in_done"}, 64'(stall), 64'd0);
    chk({tag, "_hi"}, 64'(hi), 64'(exp[63:32]));
    chk({tag, "_lo"}, 64'(lo), 64'(exp[31:0]));
    last_hi = exp[63:32];
    last_lo = exp[31:0];
    @(negedge clk);
    chk({tag, "_done_pulse"}, 64'(done), 64'd0);
  endtask

  initial begin
    int          n;
    logic        stall_bad;
    logic        hold_bad;
    logic        wrote;
    logic [31:0] ra;
    logic [31:0] rb;
    logic        rs;

    #1;
    chk("rst_hi", 64'(hi), 64'd0);
    chk("rst_lo", 64'(lo), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_stall", 64'(stall), 64'd0);
    @(negedge clk);
    rst = 1'b1;

    run_mult(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, "multu_max");
    hi_lo_sel = 1'b1;
    #1;
    chk("mux_hi", 64'(hilo_out), 64'h0000_0000_FFFF_FFFE);
    hi_lo_sel = 1'b0;
    #1;
    chk("mux_lo", 64'(hilo_out), 64'h0000_0000_0000_0001);

    run_mult(32'hFFFF_FFFD, 32'd7, 1'b1, "mult_neg");
    chk("mult_neg_hi_const", 64'(hi), 64'h0000_0000_FFFF_FFFF);
    chk("mult_neg_lo_const", 64'(lo), 64'h0000_0000_FFFF_FFEB);
    run_mult(32'hFFFF_FFFD, 32'd7, 1'b0, "multu_neg");
    chk("multu_neg_hi_const", 64'(hi), 64'h0000_0000_0000_0006);
    run_mult(32'h8000_0000, 32'h8000_0000, 1'b1, "mult_min");
    chk("mult_min_hi_const", 64'(hi), 64'h0000_0000_4000_0000);
    run_mult(32'd0, 32'h8000_0000, 1'b1, "mult_zero");

    for (int i = 0; i < 8; i++) begin
      ra = $urandom;
      rb = $urandom;
      rs = 1'($urandom_range(0, 1));
      run_mult(ra, rb, rs, $sformatf("rand%0d", i));
    end

    // Start held through the multiply with a pending MFLO; operands wiggle during RUN.
    @(negedge clk);
    a = 32'd5;
    b = 32'd6;
    signed_op = 1'b0;
    hilo_rd = 1'b1;
    hi_lo_sel = 1'b0;
    start = 1'b1;
    #1;
    chk("hold_stall_issue", 64'(stall), 64'd1);
    @(posedge clk);
    @(negedge clk);
    n = 0;
    stall_bad = 1'b0;
    hold_bad = 1'b0;
    while (done !== 1'b1 && n < 100) begin
      if (stall !== 1'b1) stall_bad = 1'b1;
      if (hilo_out !== last_lo) hold_bad = 1'b1;
      if (n == 3) begin
        a = $urandom;
        b = $urandom;
        signed_op = 1'b1;
      end
      @(negedge clk);
      n++;
    end
    start = 1'b0;
    #1;
    chk("hold_latency", 64'(n), 64'd33);
    chk("hold_stall_busy", 64'(stall_bad), 64'd0);
    chk("hold_old_value", 64'(hold_bad), 64'd0);
    chk("hold_stall_done", 64'(stall), 64'd0);
    chk("hold_result", 64'(hilo_out), 64'd30);
    hilo_rd = 1'b0;
    last_lo = 32'd30;

    // Asynchronous reset ten cycles into RUN aborts the multiply without a write.
    @(negedge clk);
    a = 32'h1234_5678;
    b = 32'h9ABC_DEF1;
    signed_op = 1'b0;
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (10) @(negedge clk);
    chk("pre_rst_lo", 64'(lo), 64'd30);
    #2;
    rst = 1'b0;
    #1;
    chk("abort_hi", 64'(hi), 64'd0);
    chk("abort_lo", 64'(lo), 64'd0);
    chk("abort_busy", 64'(busy), 64'd0);
    chk("abort_done", 64'(done), 64'd0);
    chk("abort_stall", 64'(stall), 64'd0);
    @(negedge clk);
    rst = 1'b1;
    wrote = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (done !== 1'b0 || hi !== 32'd0 || lo !== 32'd0 || busy !== 1'b0) wrote = 1'b1;
    end
    chk("abort_no_write", 64'(wrote), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/hilo_mult_unit.md
Name: hilo_mult_unit

Overview:
- Iterative radix-2 shift-add multiplier with architectural HI/LO registers.
- Sits downstream of the control unit in the single-cycle MIPS datapath and serves MULT/MULTU.
- Its start is driven by HILO_we.
- HI or LO is read out for MFHI/MFLO under the control unit's HI_LO select.
- Asserts a stall to freeze PC and register writes while a multiply is in flight.

Parameters:
- WIDTH, 32, operand width; product is 2*WIDTH, split into HI (upper) and LO (lower).
- CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-low reset.
- start  input  1  request a multiply (HILO_we from control unit); sampled only in IDLE.
- signed_op  input  1  1 = MULT (two's complement), 0 = MULTU; sampled with start.
- a  input  WIDTH  rs operand; sampled with start.
- b  input  WIDTH  rt operand; sampled with start.
- hilo_rd  input  1  current instruction is MFHI/MFLO.
- hi_lo_sel  input  1  1 = HI, 0 = LO (control unit HI_LO_mux_en).
- hilo_out  output  WIDTH  selected HI or LO; combinational from registers.
- hi  output  WIDTH  HI register.
- lo  output  WIDTH  LO register.
- busy  output  1  multiply in flight.
- done  output  1  one-cycle pulse; HI/LO updated this cycle.
- stall  output  1  freeze upstream PC/regfile write this cycle.

Behaviour:
- Reset (rst low, asynchronous):
  - State IDLE.
  - hi, lo, accumulator, multiplicand, multiplier, counter and sign flag = 0.
  - busy = 0, done = 0.
  - Takes effect immediately, including mid-operation: an in-flight multiply is aborted and HI/LO are not written.
- State machine: IDLE, RUN, FIX.
- IDLE:
  - On a clk edge with start=1, latch mcand = |a| and mplier = |b| (magnitude only if signed_op), clear acc, cnt = 0.
  - neg = signed_op & (a[WIDTH-1] ^ b[WIDTH-1]).
  - Go to RUN.
- RUN:
  - Each edge: if mplier[0], acc += mcand (2*WIDTH-bit add, no overflow possible).
  - mcand shifts left 1, mplier shifts right 1, cnt++.
  - At the edge where cnt == WIDTH-1, go to FIX.
- FIX, one edge:
  - {hi,lo} = neg ? -acc : acc (two's complement over 2*WIDTH bits).
  - Go to IDLE.
  - done = 1 for the cycle following this edge.
- Latency: start accepted at edge E0; HI/LO valid and done high in the cycle after edge E0+WIDTH+1 (33 edges for WIDTH=32).
- busy = (state != IDLE).
- stall = busy | (start & state==IDLE) | (hilo_rd & busy).
  - The issuing instruction and any MFHI/MFLO are held until the multiply completes.
  - stall drops in the done cycle.
- start while busy: ignored (no re-latch). Upstream is stalled, so this only occurs as a held request; it is re-sampled in IDLE only if it is still asserted after done. Control logic must deassert start in the done cycle (the instruction retires).
- hilo_out during busy returns the old HI/LO value; a consumer must honour stall.
- Edge cases:
  - Signed -2^(WIDTH-1) × -2^(WIDTH-1): magnitude is 2^(WIDTH-1) unsigned; the product 2^(2*WIDTH-2) fits.
  - Zero operand: result 0; neg still applied, -0 = 0.
- HI/LO change only in FIX and on reset.

Decomposition:
- Shared package mips_pkg:
  - hilo_state_t enum (IDLE, RUN, FIX).
  - MIPS_WORD = 32.
  - Function abs_word(value, signed_flag).
- Optional sub-module hilo_mult_dp: acc/mcand/mplier registers and adder, with the FSM kept in the top.
- Otherwise single module.

Test Plan:
- Reset values: assert rst low mid-RUN (after 10 RUN cycles) -> hi=lo=0, busy=0, done=0, stall=0 immediately; no later write.
- MULTU: a=0xFFFFFFFF, b=0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001; done exactly 33 edges after accept; busy high for 33 cycles.
- MULT negative: a=0xFFFFFFFD (-3), b=7 -> hi=0xFFFFFFFF, lo=0xFFFFFFEB; same a,b as MULTU -> hi=0x00000006, lo=0xFFFFFFEB.
- MULT extreme: a=b=0x80000000 signed -> hi=0x40000000, lo=0; a=0, b=0x80000000 -> hi=lo=0.
- Stall/start hold: start held high with a=5, b=6, hilo_rd=1, hi_lo_sel=0 -> stall high through RUN/FIX, low in done cycle; operand change during RUN has no effect; hilo_out shows 30 after done.
- Readout mux: after the first test, hi_lo_sel=1 -> hilo_out=0xFFFFFFFE; hi_lo_sel=0 -> 0x00000001, combinational same cycle.
